// File: rtl/controle_entrada_pkg.sv
// Shared processor constants for the input controller.
//   DEBOUNCE_CICLOS_PADRAO : default debounce window (1 ms at 50 MHz)
//   estado_t               : 2-bit encoding of the IN-instruction handshake FSM
package controle_entrada_pkg;

  localparam int unsigned DEBOUNCE_CICLOS_PADRAO = 50000;

  typedef enum logic [1:0] {
    OCIOSO        = 2'd0,
    ESPERA_PRESS  = 2'd1,
    CAPTURA       = 2'd2,
    ESPERA_SOLTAR = 2'd3
  } estado_t;

endpackage

// File: rtl/controle_entrada_debounce_botao.sv
// Button conditioner: 2-flop synchronizer followed by a counting debouncer.
// The stable level only flips after the synchronized level has disagreed
// with it for DEBOUNCE_CICLOS consecutive cycles.
//   clock         : system clock
//   reset         : asynchronous, active-low
//   botao_bruto   : raw, bouncing pushbutton (asynchronous)
//   botao_estavel : debounced level
module debounce_botao
  import controle_entrada_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
  input  logic clock,
  input  logic reset,
  input  logic botao_bruto,
  output logic botao_estavel
);

  localparam int unsigned LARG_CONT = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [LARG_CONT-1:0] LIMITE = LARG_CONT'(DEBOUNCE_CICLOS - 1);

  logic                 sinc1_q, sinc2_q;
  logic                 estavel_q, estavel_d;
  logic [LARG_CONT-1:0] cont_q, cont_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sinc1_q   <= 1'b0;
      sinc2_q   <= 1'b0;
      estavel_q <= 1'b0;
      cont_q    <= '0;
    end else begin
      sinc1_q   <= botao_bruto;
      sinc2_q   <= sinc1_q;
      estavel_q <= estavel_d;
      cont_q    <= cont_d;
    end
  end

  // Counter runs only while the synchronized level disagrees; any agreement
  // (or the flip itself) restarts it from zero.
  always_comb begin
    estavel_d = estavel_q;
    cont_d    = '0;
    if (sinc2_q != estavel_q) begin
      if (cont_q == LIMITE) begin
        estavel_d = sinc2_q;
      end else begin
        cont_d = cont_q + 1'b1;
      end
    end
  end

  assign botao_estavel = estavel_q;

endmodule

// File: rtl/controle_entrada.sv
// Input controller for the IN instruction: stalls the PC until the user
// presses the confirm button, then captures the switches into a 32-bit word
// for write-back.
//   clock, reset    : system clock, asynchronous active-low reset
//   pedido_entrada  : executing instruction is an IN
//   chaves          : board switches (quasi-static)
//   botao_confirma  : raw confirm pushbutton
//   dado_entrada    : captured word, switches zero-extended
//   entrada_pronta  : one-cycle pulse while dado_entrada is written back
//   parar_pc        : hold PC / block register write
//   aguardando      : waiting for the user (LED)
module controle_entrada
  import controle_entrada_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO,
  parameter int unsigned LARGURA_CHAVES  = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      pedido_entrada,
  input  logic [LARGURA_CHAVES-1:0] chaves,
  input  logic                      botao_confirma,
  output logic [31:0]               dado_entrada,
  output logic                      entrada_pronta,
  output logic                      parar_pc,
  output logic                      aguardando
);

  estado_t     estado_q, estado_d;
  logic [31:0] dado_q, dado_d;
  logic        botao_estavel;

  debounce_botao #(
    .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
  ) u_debounce (
    .clock        (clock),
    .reset        (reset),
    .botao_bruto  (botao_confirma),
    .botao_estavel(botao_estavel)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= OCIOSO;
      dado_q   <= '0;
    end else begin
      estado_q <= estado_d;
      dado_q   <= dado_d;
    end
  end

  // ESPERA_PRESS is only entered with the debounced level low, so seeing it
  // high there is necessarily a fresh 0->1 edge; a held button from an
  // earlier IN or from idle keeps the FSM parked in OCIOSO.
  always_comb begin
    estado_d = estado_q;
    dado_d   = dado_q;
    unique case (estado_q)
      OCIOSO: begin
        if (pedido_entrada && !botao_estavel) estado_d = ESPERA_PRESS;
      end
      ESPERA_PRESS: begin
        if (!pedido_entrada) begin
          estado_d = OCIOSO;
        end else if (botao_estavel) begin
          estado_d = CAPTURA;
          dado_d   = 32'(chaves);
        end
      end
      CAPTURA: begin
        estado_d = ESPERA_SOLTAR;
      end
      ESPERA_SOLTAR: begin
        if (!botao_estavel) estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  assign dado_entrada   = dado_q;
  assign entrada_pronta = (estado_q == CAPTURA);
  assign aguardando     = (estado_q == ESPERA_PRESS);
  assign parar_pc       = pedido_entrada && (estado_q != CAPTURA);

endmodule

// File: tb/tb_controle_entrada.sv
module tb_controle_entrada;

  logic        clock = 1'b0;
  logic        reset;
  logic        pedido_entrada;
  logic [15:0] chaves;
  logic        botao_confirma;
  logic [31:0] dado_entrada;
  logic        entrada_pronta;
  logic        parar_pc;
  logic        aguardando;

  controle_entrada #(
    .DEBOUNCE_CICLOS(4),
    .LARGURA_CHAVES (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .pedido_entrada(pedido_entrada),
    .chaves        (chaves),
    .botao_confirma(botao_confirma),
    .dado_entrada  (dado_entrada),
    .entrada_pronta(entrada_pronta),
    .parar_pc      (parar_pc),
    .aguardando    (aguardando)
  );

  always #5 clock = ~clock;

  int ciclo = 0;
  always @(posedge clock) ciclo = ciclo + 1;

  typedef struct {
    logic [31:0] dado;
    int          ciclo;
  } esperado_t;

  esperado_t fila[$];
  int errors = 0;
  int checks = 0;
  int pulsos = 0;
  int pushes = 0;

  task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] req);
    checks++;
    if (atual !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (ciclo %0d)", nome, atual, req, ciclo);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Press at the current negedge; the capture must be seen 7 edges later.
  task automatic pressiona_esperando(input logic [31:0] dado);
    esperado_t e;
    e.dado  = dado;
    e.ciclo = ciclo + 7;
    fila.push_back(e);
    pushes++;
    botao_confirma = 1'b1;
  endtask

  // Monitor: every capture pulse must match the oldest expected capture.
  always @(negedge clock) begin
    if (entrada_pronta === 1'b1) begin
      pulsos++;
      if (fila.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: entrada_pronta=1 with no capture expected (ciclo %0d)", ciclo);
      end else begin
        esperado_t e;
        e = fila.pop_front();
        check("mon_dado", dado_entrada, e.dado);
        check("mon_ciclo", 32'(ciclo), 32'(e.ciclo));
        check("mon_parar_pc", {31'b0, parar_pc}, 32'd0);
      end
    end
  end

  initial begin
    reset          = 1'b0;
    pedido_entrada = 1'b0;
    chaves         = '0;
    botao_confirma = 1'b0;

    // Reset state
    #3;
    check("rst_dado", dado_entrada, 32'd0);
    check("rst_pronta", {31'b0, entrada_pronta}, 32'd0);
    check("rst_aguard", {31'b0, aguardando}, 32'd0);
    pedido_entrada = 1'b1;
    #1;
    check("rst_parar_pc", {31'b0, parar_pc}, 32'd1);
    check("rst_aguard_ped", {31'b0, aguardando}, 32'd0);
    check("rst_pronta_ped", {31'b0, entrada_pronta}, 32'd0);
    pedido_entrada = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(2);

    // Basic IN with 0x00A5
    chaves = 16'h00A5;
    pedido_entrada = 1'b1;
    tick(1);
    check("t1_aguard_ini", {31'b0, aguardando}, 32'd1);
    check("t1_parar_ini", {31'b0, parar_pc}, 32'd1);
    pressiona_esperando(32'h0000_00A5);
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      check("t1_aguard", {31'b0, aguardando}, (k < 7) ? 32'd1 : 32'd0);
      check("t1_parar", {31'b0, parar_pc}, (k == 7) ? 32'd0 : 32'd1);
    end
    botao_confirma = 1'b0;
    tick(10);
    pedido_entrada = 1'b0;
    tick(2);

    // Glitches of 3 cycles never pass the debouncer; switches change meanwhile
    chaves = 16'h005A;
    pedido_entrada = 1'b1;
    for (int g = 0; g < 5; g++) begin
      botao_confirma = 1'b1;
      tick(3);
      botao_confirma = 1'b0;
      tick(1);
      check("t2_parar", {31'b0, parar_pc}, 32'd1);
      check("t2_aguard", {31'b0, aguardando}, 32'd1);
    end
    tick(6);
    check("t2_dado", dado_entrada, 32'h0000_00A5);
    pedido_entrada = 1'b0;
    tick(2);

    // Back-to-back INs with the button held across both
    chaves = 16'h0011;
    pedido_entrada = 1'b1;
    tick(1);
    pressiona_esperando(32'h0000_0011);
    tick(10);
    chaves = 16'h0022;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check("t3_parar_held", {31'b0, parar_pc}, 32'd1);
    end
    check("t3_dado_held", dado_entrada, 32'h0000_0011);
    botao_confirma = 1'b0;
    tick(10);
    check("t3_aguard_rearm", {31'b0, aguardando}, 32'd1);
    pressiona_esperando(32'h0000_0022);
    tick(10);
    botao_confirma = 1'b0;
    tick(10);
    pedido_entrada = 1'b0;
    tick(2);

    // Button pressed while idle, still held when the IN arrives
    botao_confirma = 1'b1;
    tick(10);
    chaves = 16'hFFFF;
    pedido_entrada = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check("t4_aguard_held", {31'b0, aguardando}, 32'd0);
      check("t4_parar_held", {31'b0, parar_pc}, 32'd1);
    end
    botao_confirma = 1'b0;
    tick(10);
    check("t4_aguard_rearm", {31'b0, aguardando}, 32'd1);
    pressiona_esperando(32'h0000_FFFF);
    tick(10);
    botao_confirma = 1'b0;
    tick(10);
    check("t4_dado_hold", dado_entrada, 32'h0000_FFFF);
    pedido_entrada = 1'b0;
    tick(2);

    // Reset during ESPERA_PRESS
    chaves = 16'h1234;
    pedido_entrada = 1'b1;
    tick(2);
    check("t5_aguard_pre", {31'b0, aguardando}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t5a_aguard", {31'b0, aguardando}, 32'd0);
    check("t5a_dado", dado_entrada, 32'd0);
    check("t5a_parar", {31'b0, parar_pc}, 32'd1);
    tick(2);
    reset = 1'b1;
    tick(2);

    // Reset during CAPTURA: the capture is discarded
    botao_confirma = 1'b1;
    tick(6);
    @(posedge clock);
    #1;
    check("t5b_pronta_pre", {31'b0, entrada_pronta}, 32'd1);
    check("t5b_dado_pre", dado_entrada, 32'h0000_1234);
    reset = 1'b0;
    botao_confirma = 1'b0;
    #1;
    check("t5b_pronta", {31'b0, entrada_pronta}, 32'd0);
    check("t5b_dado", dado_entrada, 32'd0);
    check("t5b_parar", {31'b0, parar_pc}, 32'd1);
    tick(2);
    reset = 1'b1;
    tick(10);
    check("t5_aguard_post", {31'b0, aguardando}, 32'd1);
    check("t5_dado_post", dado_entrada, 32'd0);
    chaves = 16'h0BEE;
    pressiona_esperando(32'h0000_0BEE);
    tick(10);
    botao_confirma = 1'b0;
    tick(10);
    pedido_entrada = 1'b0;
    tick(3);

    check("total_pulsos", 32'(pulsos), 32'(pushes));
    check("fila_vazia", 32'(fila.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/controle_entrada.md
CONTROLE_ENTRADA -- requirements
Module: controle_entrada

Interface
REQ-001 Parameter DEBOUNCE_CICLOS, default 50000, SHALL set the number of consecutive stable clock cycles required to accept a button level (1 ms at 50 MHz).
REQ-002 Parameter LARGURA_CHAVES, default 16, SHALL set the switch bus width; the legal range is 1..32.
REQ-003 clock  input  1  system clock; all state SHALL be updated on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 pedido_entrada  input  1  high while the executing instruction is an IN; driven by the control unit.
REQ-006 chaves  input  LARGURA_CHAVES  board switches; treated as quasi-static and not synchronized.
REQ-007 botao_confirma  input  1  raw confirm pushbutton, active-high, asynchronous and bouncing.
REQ-008 dado_entrada  output  32  captured input word, fed to the write-back operand multiplexer at select 2.
REQ-009 entrada_pronta  output  1  one-cycle pulse in the cycle in which dado_entrada is being written back.
REQ-010 parar_pc  output  1  high to hold the PC and block register write; the PC advances only when this is low.
REQ-011 aguardando  output  1  high while waiting for the user to press the button (drives an LED).

Function
REQ-012 botao_confirma SHALL pass through a 2-flop synchronizer before entering the debouncer.
REQ-013 The debounced level SHALL change only after the synchronized level differs from it for DEBOUNCE_CICLOS consecutive cycles; any interruption SHALL restart the count from 0.
REQ-014 The FSM SHALL have exactly four states: OCIOSO, ESPERA_PRESS, CAPTURA, ESPERA_SOLTAR.
REQ-015 OCIOSO SHALL go to ESPERA_PRESS when pedido_entrada=1 and the debounced level=0; otherwise it SHALL stay in OCIOSO.
REQ-016 ESPERA_PRESS SHALL go to CAPTURA on a debounced 0->1 edge.
REQ-017 ESPERA_PRESS SHALL go to OCIOSO if pedido_entrada drops.
REQ-018 On entry to CAPTURA, dado_entrada SHALL load chaves zero-extended to 32 bits.
REQ-019 CAPTURA SHALL always go to ESPERA_SOLTAR after exactly one cycle.
REQ-020 ESPERA_SOLTAR SHALL go to OCIOSO when the debounced level returns to 0.
REQ-021 Outputs:
- entrada_pronta = (state==CAPTURA).
- aguardando = (state==ESPERA_PRESS).
- parar_pc = pedido_entrada AND state!=CAPTURA (combinational).
REQ-022 Latency: the capture cycle SHALL follow the debounced press edge by 1 cycle, and the press edge SHALL follow the raw press by 2+DEBOUNCE_CICLOS cycles.
REQ-023 Presses in OCIOSO, or presses still held from a previous IN, SHALL NOT cause a capture; each IN instruction requires a fresh press edge.
REQ-024 Back-to-back IN instructions SHALL each stall until their own release and press sequence completes.
REQ-025 dado_entrada SHALL hold its last captured value outside CAPTURA.
REQ-026 Changes on chaves during any state other than the CAPTURA entry edge SHALL NOT affect dado_entrada.

Reset
REQ-027 When reset=0, asynchronously: state=OCIOSO, dado_entrada=0, synchronizer flops=0, debounced level=0, debounce counter=0.
REQ-028 With reset asserted and pedido_entrada=1, parar_pc SHALL be 1, entrada_pronta SHALL be 0 and aguardando SHALL be 0.
REQ-029 Reset asserted mid-capture or mid-wait SHALL discard the operation; after release, a new press SHALL be required.

Structure
REQ-030 The state encoding (2 bits) and the default DEBOUNCE_CICLOS value SHALL live in the shared processor constants package.
REQ-031 The synchronizer and debouncer SHALL form the sub-module debounce_botao (ports: clock, reset, botao_bruto, botao_estavel), parameterized by DEBOUNCE_CICLOS.

Verification (DEBOUNCE_CICLOS=4)
REQ-032 Raise pedido_entrada with chaves=16'h00A5, then hold the button 10 cycles -> aguardando=1 until capture; one entrada_pronta pulse 7 cycles after the raw press; dado_entrada=32'h000000A5; parar_pc=0 only in that cycle.
REQ-033 With pedido_entrada=1, apply 3-cycle glitches separated by 1-cycle gaps -> no capture; dado_entrada unchanged; parar_pc stays 1.
REQ-034 Two consecutive IN instructions with the button held continuously -> the second IN stalls in ESPERA_SOLTAR/OCIOSO until release plus a new press; exactly two entrada_pronta pulses total.
REQ-035 Press the button while pedido_entrada=0, then raise pedido_entrada with the button still held -> no capture until release and re-press.
REQ-036 Assert reset during ESPERA_PRESS and during CAPTURA -> dado_entrada=0 and state OCIOSO immediately (asynchronously); after release, a full press sequence is required.
REQ-037 LARGURA_CHAVES=16 with chaves=16'hFFFF -> dado_entrada=32'h0000FFFF (no sign extension).
